// File: rtl/fv_bank_stream_ctrl.sv
// fv_bank_stream_ctrl
//   Feature-vector bank controller. Accepts write bursts into one single-port
//   FV SRAM bank, queues read requests, and streams each queued FV word by
//   word to the tagged Edge PE with valid/ready backpressure and sos/eos
//   framing.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   num_fv                     words per FV, captured when a request is queued
//   wr_valid/ready/sos/eos     write word handshake and burst framing
//   wr_addr, wr_data           write address / data
//   rd_req_valid/ready         read request handshake (ready = queue has room)
//   rd_req_addr, rd_req_pe_tag FV start address and destination PE
//   sram_cen/wen/a/d, sram_q   SRAM port; sram_q valid one cycle after sram_cen
//   out_valid/ready/sos/eos    output stream handshake and FV framing
//   out_pe_tag, out_data       destination tag and FV word
//   busy                       FSM active, requests queued, or word on output
//   stall_cnt                  (FVB_STALL_CNT_EN only) saturating count of
//                              cycles with out_valid & !out_ready
//
// Build option: define FVB_STALL_CNT_EN to add the stall_cnt port/counter.
//
// state  | meaning
// IDLE   | free; starts a write burst, else pops a request and issues word 0
// WRITE  | write burst in progress, every wr_valid word goes to the SRAM
// STREAM | issuing the remaining reads of the current FV, one per cycle
// DRAIN  | all reads issued; waiting for in-flight data and skid FIFO to empty

module fv_bank_stream_ctrl #(
  parameter int FV_W       = 128,
  parameter int ADDR_W     = 8,
  parameter int NUM_PE     = 4,
  parameter int MAX_FV_LEN = 16,
  parameter int REQ_DEPTH  = 4,
  parameter int PE_W       = $clog2(NUM_PE),
  parameter int LEN_W      = $clog2(MAX_FV_LEN) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LEN_W-1:0]  num_fv,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_sos,
  input  logic              wr_eos,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [FV_W-1:0]   wr_data,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic [PE_W-1:0]   rd_req_pe_tag,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [FV_W-1:0]   sram_d,
  input  logic [FV_W-1:0]   sram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sos,
  output logic              out_eos,
  output logic [PE_W-1:0]   out_pe_tag,
  output logic [FV_W-1:0]   out_data,
  output logic              busy
`ifdef FVB_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int QA = $clog2(REQ_DEPTH);        // REQ_DEPTH >= 2
  localparam int QW = ADDR_W + PE_W + LEN_W;
  localparam int EW = FV_W + 2 + PE_W;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FV_LEN);
  localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_STREAM, S_DRAIN} state_t;
  state_t state, state_nxt;

  // request queue
  logic [QW-1:0]     q_mem [REQ_DEPTH];
  logic [QA:0]       q_wptr, q_rptr;
  logic              q_empty, q_full, q_push, q_pop;
  logic [LEN_W-1:0]  len_in;
  logic [QW-1:0]     q_head;
  logic [ADDR_W-1:0] h_addr;
  logic [PE_W-1:0]   h_tag;
  logic [LEN_W-1:0]  h_len;

  // read issue / stream tracking
  logic [ADDR_W-1:0] rd_addr, iss_addr;
  logic [LEN_W-1:0]  rem;                       // reads still to issue
  logic [PE_W-1:0]   cur_tag, iss_tag;
  logic              rd_issue, iss_sos, iss_eos, ld_stream, wen;
  logic              infl_vld, infl_sos, infl_eos;
  logic [PE_W-1:0]   infl_tag;

  // 2-entry output skid FIFO
  logic [EW-1:0]     sk_mem [2];
  logic              sk_wptr, sk_rptr;
  logic [1:0]        sk_cnt;
  logic [EW-1:0]     sk_head;
  logic              out_pop, can_issue;
  logic [2:0]        occ;

  assign len_in  = (num_fv == '0)     ? ONE_LEN :
                   (num_fv > MAX_LEN) ? MAX_LEN : num_fv;
  assign q_empty = (q_wptr == q_rptr);
  assign q_full  = (q_wptr[QA] != q_rptr[QA]) && (q_wptr[QA-1:0] == q_rptr[QA-1:0]);
  assign q_head  = q_mem[q_rptr[QA-1:0]];
  assign h_addr  = q_head[QW-1 -: ADDR_W];
  assign h_tag   = q_head[LEN_W +: PE_W];
  assign h_len   = q_head[LEN_W-1:0];
  assign rd_req_ready = !q_full || q_pop;
  assign q_push  = rd_req_valid && rd_req_ready;

  assign out_valid = (sk_cnt != 2'd0);
  assign out_pop   = out_valid && out_ready;
  assign sk_head   = sk_mem[sk_rptr];
  // Occupancy the FIFO will have once everything already issued lands;
  // a new read may only go out if it is guaranteed a slot.
  assign occ       = {1'b0, sk_cnt} + {2'b00, infl_vld} - {2'b00, out_pop};
  assign can_issue = (occ < 3'd2);

  assign out_data   = out_valid ? sk_head[EW-1 -: FV_W] : '0;
  assign out_sos    = out_valid && sk_head[PE_W+1];
  assign out_eos    = out_valid && sk_head[PE_W];
  assign out_pe_tag = out_valid ? sk_head[PE_W-1:0] : '0;

  assign wr_ready = (state == S_IDLE) || (state == S_WRITE);
  assign sram_wen = wen;
  assign sram_cen = rd_issue;
  assign sram_a   = wen ? wr_addr : (rd_issue ? iss_addr : '0);
  assign sram_d   = wen ? wr_data : '0;
  assign busy     = (state != S_IDLE) || !q_empty || out_valid;

  always_comb begin
    state_nxt = state;
    q_pop     = 1'b0;
    rd_issue  = 1'b0;
    iss_addr  = rd_addr;
    iss_sos   = 1'b0;
    iss_eos   = 1'b0;
    iss_tag   = cur_tag;
    ld_stream = 1'b0;
    wen       = 1'b0;
    case (state)
      S_IDLE: begin
        if (wr_valid && wr_sos) begin
          wen = 1'b1;
          if (!wr_eos) state_nxt = S_WRITE;
        end else if (!q_empty && can_issue) begin
          // word 0 goes out in the pop cycle to hit the T+1 read slot
          q_pop     = 1'b1;
          rd_issue  = 1'b1;
          ld_stream = 1'b1;
          iss_addr  = h_addr;
          iss_sos   = 1'b1;
          iss_eos   = (h_len == ONE_LEN);
          iss_tag   = h_tag;
          state_nxt = (h_len == ONE_LEN) ? S_DRAIN : S_STREAM;
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          wen = 1'b1;
          if (wr_eos) state_nxt = S_IDLE;
        end
      end
      S_STREAM: begin
        if (can_issue) begin
          rd_issue = 1'b1;
          iss_eos  = (rem == ONE_LEN);
          if (rem == ONE_LEN) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sk_cnt == 2'd0 && !infl_vld) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      q_wptr   <= '0;
      q_rptr   <= '0;
      rd_addr  <= '0;
      rem      <= '0;
      cur_tag  <= '0;
      infl_vld <= 1'b0;
      infl_sos <= 1'b0;
      infl_eos <= 1'b0;
      infl_tag <= '0;
      sk_wptr  <= 1'b0;
      sk_rptr  <= 1'b0;
      sk_cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      if (q_push) q_wptr <= q_wptr + 1'b1;
      if (q_pop)  q_rptr <= q_rptr + 1'b1;
      if (ld_stream) begin
        rd_addr <= h_addr + 1'b1;
        rem     <= h_len - 1'b1;
        cur_tag <= h_tag;
      end else if (rd_issue) begin
        rd_addr <= rd_addr + 1'b1;   // wraps modulo 2^ADDR_W
        rem     <= rem - 1'b1;
      end
      infl_vld <= rd_issue;
      infl_sos <= iss_sos;
      infl_eos <= iss_eos;
      infl_tag <= iss_tag;
      if (infl_vld) sk_wptr <= ~sk_wptr;
      if (out_pop)  sk_rptr <= ~sk_rptr;
      sk_cnt <= sk_cnt + {1'b0, infl_vld} - {1'b0, out_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (q_push)   q_mem[q_wptr[QA-1:0]] <= {rd_req_addr, rd_req_pe_tag, len_in};
    if (infl_vld) sk_mem[sk_wptr] <= {sram_q, infl_sos, infl_eos, infl_tag};
  end

`ifdef FVB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
